// File: rtl/fifo_esikli.sv
// Single-clock first-word-fall-through FIFO with any-integer depth, occupancy
// count, almost-full/almost-empty thresholds and synchronous flush.
// Define FIFO_ERR_EN to add sticky overflow_o / underflow_o status ports.
module fifo_esikli #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned DATA_DEPTH = 8,
   parameter int unsigned AF_THRESH  = DATA_DEPTH - 1,
   parameter int unsigned AE_THRESH  = 1
) (
   input  logic                               clk_i,
   input  logic                               rstn_i,
   input  logic                               flush_i,
   input  logic [DATA_WIDTH-1:0]              data_i,
   input  logic                               wr_en_i,
   output logic [DATA_WIDTH-1:0]              data_o,
   input  logic                               rd_en_i,
   output logic                               full_o,
   output logic                               empty_o,
   output logic                               almost_full_o,
   output logic                               almost_empty_o,
`ifdef FIFO_ERR_EN
   output logic                               overflow_o,
   output logic                               underflow_o,
`endif
   output logic [$clog2(DATA_DEPTH+1)-1:0]    count_o
);

   localparam int unsigned PTR_W = (DATA_DEPTH > 1) ? $clog2(DATA_DEPTH) : 1;
   localparam int unsigned CNT_W = $clog2(DATA_DEPTH + 1);
   localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(DATA_DEPTH - 1);
   localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(DATA_DEPTH);
   localparam logic [CNT_W-1:0] AF_CNT    = CNT_W'(AF_THRESH);
   localparam logic [CNT_W-1:0] AE_CNT    = CNT_W'(AE_THRESH);

   // Reject parameter sets the threshold decode cannot honour.
   if (DATA_DEPTH < 2) begin : g_bad_depth
      $error("fifo_esikli: DATA_DEPTH must be >= 2");
   end
   if ((AF_THRESH == 0) || (AF_THRESH > DATA_DEPTH)) begin : g_bad_af
      $error("fifo_esikli: AF_THRESH must be in 1..DATA_DEPTH");
   end
   if (AE_THRESH > (DATA_DEPTH - 1)) begin : g_bad_ae
      $error("fifo_esikli: AE_THRESH must be in 0..DATA_DEPTH-1");
   end

   logic [DATA_WIDTH-1:0] mem_q [DATA_DEPTH];
   logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]      count_q,  count_d;
   logic                  wr_acc_c;
   logic                  rd_acc_c;

   // Status decoded from the count register only; no input-to-flag path.
   assign full_o         = (count_q == FULL_CNT);
   assign empty_o        = (count_q == '0);
   assign almost_full_o  = (count_q >= AF_CNT);
   assign almost_empty_o = (count_q <= AE_CNT);
   assign count_o        = count_q;
   assign data_o         = mem_q[rd_ptr_q];

   // Accept decisions and pointer/count next-state; flush overrides both requests.
   always_comb begin
      wr_acc_c = wr_en_i & ~full_o  & ~flush_i;
      rd_acc_c = rd_en_i & ~empty_o & ~flush_i;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (wr_acc_c) begin
            wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + PTR_W'(1);
         end
         if (rd_acc_c) begin
            rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + PTR_W'(1);
         end
         count_d = count_q + CNT_W'(wr_acc_c) - CNT_W'(rd_acc_c);
      end
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage carries no reset; contents are only meaningful below count.
   always_ff @(posedge clk_i) begin
      if (wr_acc_c) begin
         mem_q[wr_ptr_q] <= data_i;
      end
   end

`ifdef FIFO_ERR_EN
   logic overflow_q,  overflow_d;
   logic underflow_q, underflow_d;

   // Sticky record of rejected requests, cleared by flush.
   always_comb begin
      overflow_d  = overflow_q;
      underflow_d = underflow_q;
      if (flush_i) begin
         overflow_d  = 1'b0;
         underflow_d = 1'b0;
      end else begin
         if (wr_en_i & full_o) begin
            overflow_d = 1'b1;
         end
         if (rd_en_i & empty_o) begin
            underflow_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
      end
   end

   assign overflow_o  = overflow_q;
   assign underflow_o = underflow_q;
`endif

endmodule

// File: tb/tb_fifo_esikli.sv
// Scoreboard bench for fifo_esikli at DATA_WIDTH=8, DATA_DEPTH=5, AF=4, AE=1.
module tb_fifo_esikli;

   localparam int unsigned DW    = 8;
   localparam int unsigned DEPTH = 5;
   localparam int unsigned AF    = 4;
   localparam int unsigned AE    = 1;

   logic          clk = 1'b0;
   logic          rstn;
   logic          flush;
   logic          wr_en;
   logic          rd_en;
   logic [DW-1:0] din;
   logic [DW-1:0] dout;
   logic          full, empty, af, ae;
   logic [2:0]    cnt;
`ifdef FIFO_ERR_EN
   logic          ovf, udf;
   bit            m_ovf, m_udf;
`endif

   logic [DW-1:0] sb_q[$];
   int            n_cmp = 0;
   int            n_err = 0;

   always #5 clk = ~clk;

   fifo_esikli #(
      .DATA_WIDTH(DW),
      .DATA_DEPTH(DEPTH),
      .AF_THRESH (AF),
      .AE_THRESH (AE)
   ) u_dut (
      .clk_i         (clk),
      .rstn_i        (rstn),
      .flush_i       (flush),
      .data_i        (din),
      .wr_en_i       (wr_en),
      .data_o        (dout),
      .rd_en_i       (rd_en),
      .full_o        (full),
      .empty_o       (empty),
      .almost_full_o (af),
      .almost_empty_o(ae),
`ifdef FIFO_ERR_EN
      .overflow_o    (ovf),
      .underflow_o   (udf),
`endif
      .count_o       (cnt)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Compare every observable output against the scoreboard occupancy.
   task automatic check_state();
      int n;
      n = sb_q.size();
      check("count", 32'(cnt), 32'(n));
      check("full", 32'(full), 32'(n == int'(DEPTH)));
      check("empty", 32'(empty), 32'(n == 0));
      check("almost_full", 32'(af), 32'(n >= int'(AF)));
      check("almost_empty", 32'(ae), 32'(n <= int'(AE)));
      if (n > 0) check("head", 32'(dout), 32'(sb_q[0]));
`ifdef FIFO_ERR_EN
      check("overflow", 32'(ovf), 32'(m_ovf));
      check("underflow", 32'(udf), 32'(m_udf));
`endif
   endtask

   // One clock of stimulus; called at posedge+1, returns at the next posedge+1.
   task automatic step(input logic w, input logic r, input logic f, input logic [DW-1:0] d);
      int n;
      bit wa, ra;
      wr_en = w; rd_en = r; flush = f; din = d;
      #1;
      n  = sb_q.size();
      wa = w && (n != int'(DEPTH)) && !f;
      ra = r && (n != 0) && !f;
      if (ra) check("rd_data", 32'(dout), 32'(sb_q[0]));
      @(posedge clk);
      #1;
      if (f) begin
         sb_q.delete();
      end else begin
         if (ra) void'(sb_q.pop_front());
         if (wa) sb_q.push_back(d);
      end
`ifdef FIFO_ERR_EN
      if (f) begin
         m_ovf = 1'b0;
         m_udf = 1'b0;
      end else begin
         if (w && n == int'(DEPTH)) m_ovf = 1'b1;
         if (r && n == 0)           m_udf = 1'b1;
      end
`endif
      wr_en = 1'b0; rd_en = 1'b0; flush = 1'b0;
      check_state();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      rstn = 1'b0; flush = 1'b0; wr_en = 1'b0; rd_en = 1'b0; din = '0;
`ifdef FIFO_ERR_EN
      m_ovf = 1'b0; m_udf = 1'b0;
`endif
      #12;
      check_state();
      #5 rstn = 1'b1;
      @(posedge clk);
      #1;

      // Fill and drain
      for (int i = 1; i <= 5; i++) step(1'b1, 1'b0, 1'b0, DW'(8'h11 * i));
      for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b0, 8'h00);

      // Wrap with occupancy 2 over a non-power-of-2 depth
      step(1'b1, 1'b0, 1'b0, 8'hA0);
      step(1'b1, 1'b0, 1'b0, 8'hA1);
      for (int n = 2; n < 14; n++) step(1'b1, 1'b1, 1'b0, DW'(8'hA0 + n));
      step(1'b0, 1'b1, 1'b0, 8'h00);
      step(1'b0, 1'b1, 1'b0, 8'h00);

      // Simultaneous read/write at full and at empty
      for (int i = 1; i <= 5; i++) step(1'b1, 1'b0, 1'b0, DW'(8'h30 + i));
      step(1'b1, 1'b1, 1'b0, 8'h99);
      for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0, 8'h00);
      step(1'b1, 1'b1, 1'b0, 8'h77);
      step(1'b0, 1'b1, 1'b0, 8'h00);

      // Flush with a same-cycle write
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, DW'(8'h50 + i));
      step(1'b1, 1'b1, 1'b1, 8'hEE);
      step(1'b1, 1'b0, 1'b0, 8'h01);
      step(1'b0, 1'b1, 1'b0, 8'h00);

      // Asynchronous reset between edges at count 4
      for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, DW'(8'hC0 + i));
      #2 rstn = 1'b0;
      #1;
      sb_q.delete();
`ifdef FIFO_ERR_EN
      m_ovf = 1'b0; m_udf = 1'b0;
`endif
      check_state();
      wr_en = 1'b1; din = 8'hDD;
      @(posedge clk);
      #1;
      check_state();
      wr_en = 1'b0;
      #3 rstn = 1'b1;
      @(posedge clk);
      #1;
      check_state();
      step(1'b1, 1'b0, 1'b0, 8'h5A);
      step(1'b1, 1'b1, 1'b0, 8'h5B);
      step(1'b0, 1'b1, 1'b0, 8'h00);

`ifdef FIFO_ERR_EN
      // Sticky error flags
      for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 1'b0, DW'(8'h60 + i));
      step(1'b0, 1'b0, 1'b0, 8'h00);
      step(1'b0, 1'b0, 1'b1, 8'h00);
      step(1'b0, 1'b1, 1'b0, 8'h00);
      step(1'b0, 1'b0, 1'b0, 8'h00);
      step(1'b0, 1'b0, 1'b1, 8'h00);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
